// File: rtl/rejunity_vga_test01_pkg.sv
// Shared VGA 640x480@60Hz timing constants, screen centre and colour helpers
// for the water-drop ripple tile.
package rejunity_vga_test01_pkg;

    localparam logic [9:0] H_ACTIVE = 10'd640;
    localparam logic [9:0] H_FRONT  = 10'd16;
    localparam logic [9:0] H_SYNC   = 10'd96;
    localparam logic [9:0] H_BACK   = 10'd48;
    localparam logic [9:0] H_TOTAL  = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
    localparam logic [9:0] H_MAX    = H_TOTAL - 10'd1;
    localparam logic [9:0] H_SYNC_START = H_ACTIVE + H_FRONT;
    localparam logic [9:0] H_SYNC_END   = H_SYNC_START + H_SYNC;

    localparam logic [9:0] V_ACTIVE = 10'd480;
    localparam logic [9:0] V_FRONT  = 10'd10;
    localparam logic [9:0] V_SYNC   = 10'd2;
    localparam logic [9:0] V_BACK   = 10'd33;
    localparam logic [9:0] V_TOTAL  = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;
    localparam logic [9:0] V_MAX    = V_TOTAL - 10'd1;
    localparam logic [9:0] V_SYNC_START = V_ACTIVE + V_FRONT;
    localparam logic [9:0] V_SYNC_END   = V_SYNC_START + V_SYNC;

    localparam logic [9:0] H_CENTRE = 10'd320;
    localparam logic [9:0] V_CENTRE = 10'd240;

    localparam logic [7:0] UO_RESET = 8'h88;

    typedef struct packed {
        logic [1:0] r;
        logic [1:0] g;
        logic [1:0] b;
    } rgb_t;

    function automatic logic [9:0] abs_diff(input logic [9:0] a, input logic [9:0] b);
        return (a >= b) ? (a - b) : (b - a);
    endfunction

    // TinyVGA PMOD ordering: low colour bits on the upper nibble next to hsync.
    function automatic logic [7:0] tinyvga_pack(input logic hs, input logic vs, input rgb_t c);
        return {hs, c.b[0], c.g[0], c.r[0], vs, c.b[1], c.g[1], c.r[1]};
    endfunction

endpackage

// File: rtl/rejunity_vga_test01_vga_hvsync_gen.sv
// Free-running 800x525 raster counters with active-low syncs and the
// visible-area flag, all decoded combinationally from the counter state.
module vga_hvsync_gen
    import rejunity_vga_test01_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    output logic [9:0] hpos,
    output logic [9:0] vpos,
    output logic       hsync,
    output logic       vsync,
    output logic       display_on
);

    logic [9:0] hpos_q, hpos_d;
    logic [9:0] vpos_q, vpos_d;

    always_comb begin
        hpos_d = hpos_q + 10'd1;
        vpos_d = vpos_q;
        if (hpos_q == H_MAX) begin
            hpos_d = '0;
            vpos_d = (vpos_q == V_MAX) ? 10'd0 : (vpos_q + 10'd1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hpos_q <= '0;
            vpos_q <= '0;
        end else begin
            hpos_q <= hpos_d;
            vpos_q <= vpos_d;
        end
    end

    assign hpos       = hpos_q;
    assign vpos       = vpos_q;
    assign hsync      = !((hpos_q >= H_SYNC_START) && (hpos_q < H_SYNC_END));
    assign vsync      = !((vpos_q >= V_SYNC_START) && (vpos_q < V_SYNC_END));
    assign display_on = (hpos_q < H_ACTIVE) && (vpos_q < V_ACTIVE);

endmodule

// File: rtl/rejunity_vga_test01.sv
// Tiny Tapeout tile: diamond ripples expanding from screen centre on TinyVGA.
// Sync and colour share one output register, so they stay aligned.
module rejunity_vga_test01
    import rejunity_vga_test01_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic [7:0] ui_in,
    input  logic [7:0] uio_in,
    output logic [7:0] uo_out,
    output logic [7:0] uio_out,
    output logic [7:0] uio_oe
);

    logic [9:0]  hpos, vpos;
    logic        hsync, vsync, display_on;

    logic [7:0]  frame_q, frame_d;
    logic [7:0]  uo_q, uo_d;
    logic [9:0]  dx, dy;
    logic [10:0] r, phase;
    rgb_t        pix;
    logic        pause;
    logic        frame_tick;

    vga_hvsync_gen u_hvsync (
        .clk        (clk),
        .rst_n      (rst_n),
        .hpos       (hpos),
        .vpos       (vpos),
        .hsync      (hsync),
        .vsync      (vsync),
        .display_on (display_on)
    );

    assign pause      = ui_in[0];
    assign frame_tick = (hpos == 10'd0) && (vpos == V_ACTIVE);

    always_comb begin
        frame_d = frame_q;
        if (frame_tick && !pause) begin
            frame_d = frame_q + 8'd1;
        end
    end

    // Manhattan distance gives diamond-shaped rings; subtracting 2*frame
    // makes them drift outward by two pixels per frame.
    always_comb begin
        dx    = abs_diff(hpos, H_CENTRE);
        dy    = abs_diff(vpos, V_CENTRE);
        r     = {1'b0, dx} + {1'b0, dy};
        phase = r - {2'b00, frame_q, 1'b0};
        pix   = '0;
        if (display_on) begin
            pix.r = phase[5:4];
            pix.g = phase[6:5];
            pix.b = phase[7:6];
        end
        uo_d = tinyvga_pack(hsync, vsync, pix);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_q <= '0;
            uo_q    <= UO_RESET;
        end else begin
            frame_q <= frame_d;
            uo_q    <= uo_d;
        end
    end

    assign uo_out  = uo_q;
    assign uio_out = 8'h00;
    assign uio_oe  = 8'h00;

    logic unused_inputs;
    assign unused_inputs = &{1'b0, ena, uio_in, ui_in[7:1], phase[10:8], phase[3:0]};

endmodule

// File: tb/tb_rejunity_vga_test01.sv
// Self-checking bench for the VGA ripple tile: fixed pixel vectors, sync
// timing measurement and a per-cycle scoreboard against a raster model.
module tb_rejunity_vga_test01;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       ena = 1'b1;
    logic [7:0] ui_in = 8'h00;
    logic [7:0] uio_in = 8'h00;
    logic [7:0] uo_out, uio_out, uio_oe;

    rejunity_vga_test01 dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .ena     (ena),
        .ui_in   (ui_in),
        .uio_in  (uio_in),
        .uo_out  (uo_out),
        .uio_out (uio_out),
        .uio_oe  (uio_oe)
    );

    always #20 clk = ~clk;

    localparam longint LINE  = 800;
    localparam longint FRAME = 420000;

    int total = 0;
    int passed = 0;
    bit pause = 1'b0;

    // Reference: output for pixel (h,v) of an animation frame f, from the rules.
    function automatic logic [7:0] model_pixel(input int h, input int v, input int f);
        int dx, dy, ph;
        logic [1:0] rr, gg, bb;
        logic hs, vs;
        dx = (h >= 320) ? h - 320 : 320 - h;
        dy = (v >= 240) ? v - 240 : 240 - v;
        ph = (dx + dy - 2 * f) & 2047;
        rr = 2'((ph >> 4) & 3);
        gg = 2'((ph >> 5) & 3);
        bb = 2'((ph >> 6) & 3);
        if (!(h < 640 && v < 480)) begin
            rr = 2'd0; gg = 2'd0; bb = 2'd0;
        end
        hs = !(h >= 656 && h < 752);
        vs = !(v >= 490 && v < 492);
        return {hs, bb[0], gg[0], rr[0], vs, bb[1], gg[1], rr[1]};
    endfunction

    // n = clock edges since reset release; pixel index n is shown after edge n+1.
    longint     n;
    int         mframe;
    logic [7:0] exp_q;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            n      <= 0;
            mframe <= 0;
            exp_q  <= 8'h88;
        end else begin
            exp_q <= model_pixel(int'(n % LINE), int'((n / LINE) % 525), mframe);
            if ((n % FRAME) == 384000 && !ui_in[0]) mframe <= (mframe + 1) % 256;
            n <= n + 1;
        end
    end

    task automatic check(input string name, input longint act, input longint req);
        total++;
        if (act == req) passed++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    endtask

    int     line_mis = 0;
    bit     prev_hs = 1'b1, prev_vs = 1'b1;
    int     hs_nf = 0, vs_nf = 0;
    longint hs_f[2], vs_f[2];
    longint hs_r = 0, vs_r = 0;

    task automatic tick();
        @(negedge clk);
        if (rst_n && n > 0) begin
            if (uo_out !== exp_q || uio_out !== 8'h00 || uio_oe !== 8'h00) line_mis++;
            if ((n - 1) % LINE == LINE - 1) begin
                check($sformatf("line_scoreboard_%0d", (n - 1) / LINE), line_mis, 0);
                line_mis = 0;
            end
            if (prev_hs && !uo_out[7] && hs_nf < 2) begin hs_f[hs_nf] = n; hs_nf++; end
            if (!prev_hs && uo_out[7] && hs_r == 0) hs_r = n;
            if (prev_vs && !uo_out[3] && vs_nf < 2) begin vs_f[vs_nf] = n; vs_nf++; end
            if (!prev_vs && uo_out[3] && vs_r == 0) vs_r = n;
            prev_hs = uo_out[7];
            prev_vs = uo_out[3];
        end else begin
            prev_hs = 1'b1;
            prev_vs = 1'b1;
        end
        ui_in  = {7'($urandom), pause};
        uio_in = 8'($urandom);
        ena    = 1'($urandom);
    endtask

    task automatic wait_edges(input longint target, input string name);
        longint guard = 0;
        while (n < target && guard < 2000000) begin
            tick();
            guard++;
        end
        if (n != target) begin
            total++;
            $display("FAIL %s_timeout: edge count %0d, required %0d", name, n, target);
        end
    endtask

    typedef struct {
        string      name;
        int         h;
        int         v;
        logic [7:0] req;
    } vec_t;

    vec_t tbl[13];

    initial begin
        tbl[0]  = '{"pix_0_0",     0,   0,   8'hB9};
        tbl[1]  = '{"blank_640_0", 640, 0,   8'h88};
        tbl[2]  = '{"hs_start",    656, 0,   8'h08};
        tbl[3]  = '{"hs_last",     751, 0,   8'h08};
        tbl[4]  = '{"hs_end",      752, 0,   8'h88};
        tbl[5]  = '{"pix_16_240",  16,  240, 8'hB9};
        tbl[6]  = '{"centre",      320, 240, 8'h88};
        tbl[7]  = '{"pix_400_300", 400, 300, 8'h8C};
        tbl[8]  = '{"pix_639_479", 639, 479, 8'hA9};
        tbl[9]  = '{"blank_v480",  16,  480, 8'h88};
        tbl[10] = '{"vs_start",    100, 490, 8'h80};
        tbl[11] = '{"vs_last",     100, 491, 8'h80};
        tbl[12] = '{"vs_end",      100, 492, 8'h88};

        repeat (3) tick();
        check("reset_uo_out", uo_out, 8'h88);
        check("reset_uio_out", uio_out, 8'h00);
        check("reset_uio_oe", uio_oe, 8'h00);
        rst_n = 1'b1;
        #1;
        check("release_idle", uo_out, 8'h88);

        // Frame 0 vectors, in raster order.
        for (int i = 0; i < 13; i++) begin
            wait_edges(longint'(tbl[i].v) * LINE + tbl[i].h + 1, tbl[i].name);
            check(tbl[i].name, uo_out, tbl[i].req);
        end

        // Frame 1: ring has moved two pixels outward.
        wait_edges(FRAME + 240 * LINE + 16 + 1, "frame1");
        check("frame1_pix_16_240", uo_out, 8'hA9);

        // Pause: colour holds across the next two frames.
        pause = 1'b1;
        wait_edges(2 * FRAME + 240 * LINE + 16 + 1, "frame2");
        check("paused_f2_pix_16_240", uo_out, 8'hA9);
        wait_edges(3 * FRAME + 240 * LINE + 16 + 1, "frame3");
        check("paused_f3_pix_16_240", uo_out, 8'hA9);

        check("hsync_first_fall", hs_f[0], 657);
        check("hsync_low_width", hs_r - hs_f[0], 96);
        check("hsync_period", hs_f[1] - hs_f[0], 800);
        check("vsync_first_fall", vs_f[0], 392001);
        check("vsync_low_width", vs_r - vs_f[0], 1600);
        check("vsync_period", vs_f[1] - vs_f[0], 420000);

        // Asynchronous reset mid-frame, then restart from pixel (0,0), frame 0.
        pause = 1'b0;
        repeat (100) tick();
        #5 rst_n = 1'b0;
        #1;
        check("async_reset_uo_out", uo_out, 8'h88);
        repeat (3) tick();
        rst_n = 1'b1;
        line_mis = 0;
        tick();
        check("post_reset_pix_0_0", uo_out, 8'hB9);
        wait_edges(LINE + 1, "post_reset_line");

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/rejunity_vga_test01.md
Name: rejunity_vga_test01

Overview:
Tiny Tapeout user tile that generates a 640x480@60Hz VGA "water drop" demo. It produces concentric diamond ripples centred on the screen that move outward once per frame. Output is on the TinyVGA PMOD pinout of uo_out. The bidirectional pins are unused.

Parameters:
H_ACTIVE, 640, visible pixels per line
H_FRONT/H_SYNC/H_BACK, 16/96/48, horizontal porch and sync widths (line = 800 clocks)
V_ACTIVE, 480, visible lines
V_FRONT/V_SYNC/V_BACK, 10/2/33, vertical porch and sync widths (frame = 525 lines)

Ports:
clk  in  1  pixel clock, nominal 25.175 MHz
rst_n  in  1  reset; asynchronous, active-low
ena  in  1  tile enable; ignored
ui_in  in  8  bit0 = pause animation; bits 7:1 unused
uio_in  in  8  unused
uo_out  out  8  {hsync, B[0], G[0], R[0], vsync, B[1], G[1], R[1]} (bit7..bit0)
uio_out  out  8  constant 0
uio_oe  out  8  constant 0 (all inputs)

Behaviour:
- One clock domain (clk). Reset is asynchronous and active-low on rst_n.
- Reset values:
  - hpos = 0, vpos = 0, frame = 0.
  - uo_out = 8'h88: syncs inactive-high, RGB = 0.
- hpos (10 bit):
  - Counts 0..799, then wraps to 0.
  - At wrap, vpos (10 bit) counts 0..524, then wraps to 0.
- hsync is low for hpos 656..751.
- vsync is low for vpos 490..491.
- display_on = (hpos < 640) && (vpos < 480).
- frame (8 bit):
  - Increments once per frame on the clock where hpos==0 and vpos==480.
  - Held when ui_in[0]=1.
  - Wraps 255 -> 0.
- Effect (all unsigned):
  - dx = |hpos - 320|, dy = |vpos - 240|.
  - r = dx + dy (11 bit).
  - phase = r - {frame, 1'b0} (11 bit, modulo arithmetic).
  - R = phase[5:4], G = phase[6:5], B = phase[7:6].
- RGB is forced to 0 when display_on = 0.
- All of uo_out is registered. Sync and colour for counter state (hpos, vpos) appear together on uo_out one clock later, so the relative sync/pixel alignment is unaffected.
- Reset asserted mid-frame immediately returns outputs to 8'h88 and counters to 0.

Decomposition:
- Shared package holds the timing constants (H_* and V_*, line = 800, frame = 525) and the screen centre constants (320, 240).
- One sub-module, vga_hvsync_gen:
  - Inputs: clk, rst_n.
  - Outputs: hpos, vpos, hsync, vsync, display_on.
- The top level holds the frame counter, the effect arithmetic and the output register.

Test Plan:
- Reset: assert rst_n=0 -> uo_out=8'h88, uio_out=0, uio_oe=0. Release -> uo_out stays 8'h88 until the first visible pixel's colour or a sync pulse.
- Horizontal timing: free-run 2 lines -> hsync (uo_out[7]) period 800 clocks, low for exactly 96 clocks, falling edge 656 clocks after hpos 0.
- Vertical timing: run 1 full frame -> vsync (uo_out[3]) period 420000 clocks, low for exactly 1600 clocks.
- Pixel colour, frame 0:
  - Pixel (320,240) -> RGB all 0.
  - Pixel (16,240): r=304, so R=3, G=1, B=0 -> uo_out bits {4,0}=1,1, bit5=1, bit1=0, bits {6,2}=0.
- Blanking: pixels with hpos >= 640 or vpos >= 480 -> uo_out bits 6:4 and 2:0 are all 0.
- Animation and pause:
  - Pause clear: after 1 frame, pixel (16,240) has phase=302 -> R=2, G=1, B=0.
  - ui_in[0]=1: the same pixel keeps its previous colour across 2 frames.
